spr_bank: RTL and testbench
===========================

Name: spr_bank

Overview:
Parametrised special-purpose register bank; next generation of the 32x32 SPR RAM.
- Keeps the per-register parallel load (ce vector plus flat data bus), the addressed single-word write, and the addressed read.
- Adds a registered read port with optional write bypass.
- Adds a context-dump stream (registers out, valid/ready) and a context-restore stream (registers in, valid/ready), run by an internal FSM.
- Sits beside the core register file. Used for interrupt context save/restore and debug readout.

Parameters:
NREGS, 32, number of registers (2..64; need not be a power of 2)
WIDTH, 32, bits per register
AW, clog2(NREGS), address width (derived; not user-overridden)
RESET_VAL, 0, value every register takes on reset
BYPASS, 1, 1 = read of a register written in the same cycle returns the new value

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
we  in  1  write strobe for ce/addr writes
addr  in  AW  target register for a din write
ce  in  NREGS  per-register parallel-load enables, qualified by we
din_flat  in  NREGS*WIDTH  parallel-load data; register i uses bits [i*WIDTH +: WIDTH]
din  in  WIDTH  addressed write data
rd_addr  in  AW  read address
dout  out  WIDTH  registered read data
dump_start  in  1  one-cycle request to stream all registers out
restore_start  in  1  one-cycle request to stream all registers in
busy  out  1  FSM not in IDLE
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts dump beat
dump_data  out  WIDTH  dump beat data
dump_last  out  1  marks beat for register NREGS-1
ld_valid  in  1  restore beat valid
ld_ready  out  1  bank accepts restore beat
ld_data  in  WIDTH  restore beat data
done  out  1  one-cycle pulse when a dump or restore completes

Behaviour:
Reset:
- All registers = RESET_VAL.
- dout = 0; dump_data = 0; dump_valid = ld_ready = dump_last = busy = done = 0.
- FSM = IDLE; idx = 0.

Host write (we=1), per register i, evaluated in the same cycle:
- If ce[i]=1, register i loads din_flat slice i.
- Else if addr==i, register i loads din.
- ce has priority over addr for the same register.
- Any number of ce bits may be set together.
- addr >= NREGS: the din write is ignored; ce writes still apply.

Read:
- dout updates at clk+1 with reg[rd_addr]. Latency is 1.
- With BYPASS=1 and a same-cycle write hitting rd_addr, dout takes the written value.
- With BYPASS=0, dout takes the old value.
- rd_addr >= NREGS: dout = 0.

FSM states: IDLE, DUMP, RESTORE.
- In IDLE: dump_start=1 -> DUMP with idx=0. Otherwise restore_start=1 -> RESTORE with idx=0. If both are asserted, dump wins.
- Starts while busy=1 are ignored.

DUMP:
- On entry, the output stage loads reg[0] and asserts dump_valid the next cycle.
- dump_data and dump_last are held stable while dump_valid=1 and dump_ready=0.
- On handshake (valid & ready): idx increments and the stage reloads with reg[idx+1] (1 beat/cycle under continuous ready).
- Each beat samples the live register value at load time; host writes to an already-loaded beat do not alter it.
- Handshake with dump_last=1 -> dump_valid=0, done pulses next cycle, FSM -> IDLE.

RESTORE:
- ld_ready = 1 except in cycles where we=1 (host writes have priority).
- On ld_valid & ld_ready: reg[idx] <= ld_data and idx increments.
- Beat at idx=NREGS-1 -> done pulses next cycle, FSM -> IDLE, ld_ready=0.

Other rules:
- Host writes and reads stay functional in every state.
- rst_n low mid-stream: the stream aborts immediately, all state returns to reset values, and done is not pulsed.

Decomposition:
- Package spr_pkg holds: state enum (IDLE/DUMP/RESTORE), the clog2 function for AW, and the default NREGS/WIDTH constants.
- Sub-module spr_stream_ctrl holds the FSM, idx counter, dump output stage and handshakes.
- Top spr_bank holds the register array, write decode, and read/bypass mux.

Test Plan:
- Reset with RESET_VAL=32'h0: read any register -> dout=0; busy=0.
- ce=32'h20, din_flat slice5=A5A5A5A5, we=1 -> after rd_addr=5, dout=A5A5A5A5.
- ce=0, addr=10, din=DEADBEEF, we=1 -> reg10=DEADBEEF; reg7 unchanged at 0.
- Same cycle: ce[3]=1 (slice3=11111111), addr=3, din=22222222 -> reg3=11111111.
- Same cycle: write reg4=CAFEF00D with rd_addr=4 -> dout=CAFEF00D next cycle (BYPASS=1); old value when BYPASS=0.
- dump_start, then dump_ready toggled 1,0,1 -> 32 beats in order with data held during stalls, dump_last on beat 31, done pulse.
- Then restore_start with ld_data=i*0x01010101 and we=1 on beat 7 -> ld_ready low that cycle, all regs=i*0x01010101, done pulse.
- rst_n pulsed low mid-dump (beat 12) -> dump_valid=0, busy=0, regs=RESET_VAL, no done pulse.

Source files
------------

// File: rtl/spr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spr_pkg : shared types and constants for the SPR bank                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spr_pkg;

    localparam int DEF_NREGS = 32;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DUMP    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spr_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spr_stream_ctrl : dump/restore sequencer, index counter, dump stage  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spr_stream_ctrl
    import spr_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             dump_start,
    input  logic             restore_start,
    input  logic             dump_ready,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic [AW-1:0]    load_idx,
    output logic [AW-1:0]    idx,
    output logic             ld_wr,
    output logic             busy,
    output logic             dump_valid,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_last,
    output logic             ld_ready,
    output logic             done
);

    state_t           state, state_nxt;
    logic [AW-1:0]    idx_nxt;
    logic             dv_nxt, dl_nxt, done_nxt;
    logic [WIDTH-1:0] dd_nxt;

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dv_nxt    = dump_valid;
        dd_nxt    = dump_data;
        dl_nxt    = dump_last;
        done_nxt  = 1'b0;
        load_idx  = idx + 1'b1;
        // Host writes own the bank in any cycle they occur.
        ld_ready  = (state == ST_RESTORE) && !we;
        ld_wr     = ld_valid && ld_ready;
        case (state)
            ST_IDLE: begin
                load_idx = '0;
                if (dump_start) begin
                    state_nxt = ST_DUMP;
                    idx_nxt   = '0;
                    dv_nxt    = 1'b1;
                    dd_nxt    = load_data;
                    dl_nxt    = 1'b0;
                end else if (restore_start) begin
                    state_nxt = ST_RESTORE;
                    idx_nxt   = '0;
                end
            end
            ST_DUMP: begin
                if (dump_valid && dump_ready) begin
                    if (dump_last) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                        dv_nxt    = 1'b0;
                        dl_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                        dd_nxt  = load_data;
                        dl_nxt  = (int'(idx) + 1 == NREGS - 1);
                    end
                end
            end
            ST_RESTORE: begin
                if (ld_wr) begin
                    if (int'(idx) == NREGS - 1) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            dump_valid <= dv_nxt;
            dump_data  <= dd_nxt;
            dump_last  <= dl_nxt;
            done       <= done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spr_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spr_bank : parametrised SPR bank with registered read and streaming  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spr_bank
    import spr_pkg::*;
#(
    parameter int               NREGS     = DEF_NREGS,
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               BYPASS    = 1'b1,
    localparam int              AW        = clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [NREGS-1:0]       ce,
    input  logic [NREGS*WIDTH-1:0] din_flat,
    input  logic [WIDTH-1:0]       din,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       dout,
    input  logic                   dump_start,
    input  logic                   restore_start,
    output logic                   busy,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [WIDTH-1:0]       dump_data,
    output logic                   dump_last,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   done
);

    logic [WIDTH-1:0] regs     [NREGS];
    logic [WIDTH-1:0] regs_nxt [NREGS];
    logic [AW-1:0]    load_idx, idx;
    logic [WIDTH-1:0] load_data;
    logic             ld_wr;

    spr_stream_ctrl #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .we            (we),
        .dump_start    (dump_start),
        .restore_start (restore_start),
        .dump_ready    (dump_ready),
        .ld_valid      (ld_valid),
        .load_data     (load_data),
        .load_idx      (load_idx),
        .idx           (idx),
        .ld_wr         (ld_wr),
        .busy          (busy),
        .dump_valid    (dump_valid),
        .dump_data     (dump_data),
        .dump_last     (dump_last),
        .ld_ready      (ld_ready),
        .done          (done)
    );

    assign load_data = (int'(load_idx) < NREGS) ? regs[load_idx] : '0;

    // ce beats addr for the same register; restore never collides since ld_ready drops on we.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_nxt[i] = regs[i];
            if (we && ce[i])
                regs_nxt[i] = din_flat[i*WIDTH +: WIDTH];
            else if (we && int'(addr) == i)
                regs_nxt[i] = din;
            else if (ld_wr && int'(idx) == i)
                regs_nxt[i] = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
            dout <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs[i] <= regs_nxt[i];
            if (int'(rd_addr) < NREGS)
                dout <= BYPASS ? regs_nxt[rd_addr] : regs[rd_addr];
            else
                dout <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spr_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spr_bank : randomized scoreboard bench for spr_bank               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spr_bank;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we, dump_start, restore_start, dump_ready, ld_valid;
    logic [4:0]    addr, rd_addr;
    logic [31:0]   ce, din, ld_data;
    logic [1023:0] din_flat;
    logic [31:0]   dout, dump_data, dout_nb, nb_dump_data;
    logic          busy, dump_valid, dump_last, ld_ready, done;
    logic          nb_busy, nb_dump_valid, nb_dump_last, nb_ld_ready, nb_done;

    int n_vec = 0, n_fail = 0, done_cnt = 0, beats_seen = 0;

    logic [31:0] mreg [32];
    logic        m_dump = 1'b0, m_restore = 1'b0;
    int          m_ridx = 0;
    beat_t       dump_q [$];
    logic [31:0] dq1 [$], dq0 [$];
    logic        busy_q [$], ldr_q [$];

    always #5 clk = ~clk;

    spr_bank #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .ce(ce), .din_flat(din_flat),
        .din(din), .rd_addr(rd_addr), .dout(dout), .dump_start(dump_start),
        .restore_start(restore_start), .busy(busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .done(done)
    );

    spr_bank #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .ce(ce), .din_flat(din_flat),
        .din(din), .rd_addr(rd_addr), .dout(dout_nb), .dump_start(dump_start),
        .restore_start(restore_start), .busy(nb_busy), .dump_valid(nb_dump_valid),
        .dump_ready(dump_ready), .dump_data(nb_dump_data), .dump_last(nb_dump_last),
        .ld_valid(ld_valid), .ld_ready(nb_ld_ready), .ld_data(ld_data), .done(nb_done)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: mid-cycle, after the driver has settled this cycle's inputs.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (busy_q.size() > 0) chk("busy", busy, busy_q.pop_front());
            if (ldr_q.size() > 0)  chk("ld_ready", ld_ready, ldr_q.pop_front());
            if (dq1.size() > 0)    chk("dout_bypass", dout, dq1.pop_front());
            if (dq0.size() > 0)    chk("dout_nobypass", dout_nb, dq0.pop_front());
            if (done) done_cnt++;
            if (dump_valid) begin
                if (dump_q.size() == 0) begin
                    chk("dump_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    chk("dump_data", dump_data, dump_q[0].d);
                    chk("dump_last", dump_last, dump_q[0].last);
                    if (dump_ready) begin
                        beats_seen++;
                        if (dump_q[0].last) m_dump = 1'b0;
                        void'(dump_q.pop_front());
                    end
                end
            end
        end
    end

    // Applies this cycle's inputs to the reference model across one clock edge.
    task automatic step();
        logic [31:0] nreg [32];
        logic        busy_pre, exp_ldr;
        beat_t       b;
        busy_pre = m_dump || m_restore;
        exp_ldr  = m_restore && !we;
        busy_q.push_back(busy_pre);
        ldr_q.push_back(exp_ldr);
        nreg = mreg;
        if (we)
            for (int i = 0; i < 32; i++)
                if (ce[i]) nreg[i] = din_flat[i*32 +: 32];
                else if (int'(addr) == i) nreg[i] = din;
        if (ld_valid && exp_ldr) begin
            nreg[m_ridx] = ld_data;
            if (m_ridx == 31) m_restore = 1'b0;
            else m_ridx++;
        end
        if (!busy_pre) begin
            if (dump_start) begin
                m_dump = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    b.d = nreg[i];
                    b.last = (i == 31);
                    dump_q.push_back(b);
                end
            end else if (restore_start) begin
                m_restore = 1'b1;
                m_ridx = 0;
            end
        end
        @(posedge clk);
        dq1.push_back(nreg[rd_addr]);
        dq0.push_back(mreg[rd_addr]);
        mreg = nreg;
        @(negedge clk);
    endtask

    task automatic quiet();
        we = 1'b0; ce = '0; dump_start = 1'b0; restore_start = 1'b0;
        ld_valid = 1'b0; dump_ready = 1'b0;
    endtask

    task automatic reset_checks();
        #2;
        chk("rst_dout", dout, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_dump_valid", dump_valid, 32'h0);
        chk("rst_dump_data", dump_data, 32'h0);
        chk("rst_dump_last", dump_last, 32'h0);
        chk("rst_ld_ready", ld_ready, 32'h0);
        chk("rst_done", done, 32'h0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            step();
        end
    endtask

    initial begin
        int base_done, base_beats;
        bit did7;
        rst_n = 1'b0; quiet(); addr = '0; rd_addr = '0; din = '0; din_flat = '0; ld_data = '0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        repeat (3) @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        read_all();

        // Directed host writes and read-port behaviour.
        we = 1'b1; ce = 32'h20; din_flat[5*32 +: 32] = 32'hA5A5A5A5; step();
        quiet(); rd_addr = 5'd5; step();
        we = 1'b1; addr = 5'd10; din = 32'hDEADBEEF; step();
        quiet(); rd_addr = 5'd10; step();
        rd_addr = 5'd7; step();
        we = 1'b1; ce = 32'h8; din_flat[3*32 +: 32] = 32'h11111111; addr = 5'd3; din = 32'h22222222; step();
        quiet(); rd_addr = 5'd3; step();
        we = 1'b1; addr = 5'd4; din = 32'hCAFEF00D; rd_addr = 5'd4; step();
        quiet(); step();

        // Random host traffic.
        for (int c = 0; c < 200; c++) begin
            we = 1'($urandom_range(0, 1));
            ce = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : 32'h0;
            addr = 5'($urandom); din = $urandom; rd_addr = 5'($urandom);
            for (int i = 0; i < 32; i++) din_flat[i*32 +: 32] = $urandom;
            step();
        end

        // Dump with ready pattern 1,0,1; both starts together, and starts while busy.
        quiet(); base_done = done_cnt; base_beats = beats_seen;
        dump_start = 1'b1; restore_start = 1'b1; step();
        for (int c = 0; c < 300 && m_dump; c++) begin
            quiet();
            dump_ready = (c % 3 != 1);
            dump_start = (c == 5); restore_start = (c == 6);
            rd_addr = 5'($urandom);
            step();
        end
        chk("dump_timeout", m_dump, 32'h0);
        quiet(); repeat (3) step();
        chk("dump_beats", beats_seen - base_beats, 32);
        chk("dump_done_pulses", done_cnt - base_done, 32'd1);
        chk("dump_leftover", dump_q.size(), 32'h0);

        // Restore i*0x01010101 with a host write stealing the beat-7 slot.
        base_done = done_cnt; did7 = 1'b0;
        restore_start = 1'b1; step();
        for (int c = 0; c < 300 && m_restore; c++) begin
            quiet();
            ld_data = 32'(m_ridx) * 32'h01010101;
            ld_valid = ($urandom_range(0, 3) != 0);
            if (m_ridx == 7 && !did7) begin
                we = 1'b1; addr = 5'd20; din = 32'h12345678; ld_valid = 1'b1; did7 = 1'b1;
            end
            rd_addr = 5'($urandom);
            step();
        end
        chk("restore_timeout", m_restore, 32'h0);
        quiet(); repeat (3) step();
        chk("restore_done_pulses", done_cnt - base_done, 32'd1);
        for (int i = 0; i < 32; i++)
            chk("restore_model", mreg[i], 32'(i) * 32'h01010101);
        read_all();

        // Reset in the middle of a dump.
        base_beats = beats_seen;
        dump_start = 1'b1; step();
        for (int c = 0; c < 200 && (beats_seen - base_beats) < 12; c++) begin
            quiet(); dump_ready = 1'b1; rd_addr = 5'($urandom); step();
        end
        chk("mid_dump_reached", ((beats_seen - base_beats) >= 12) ? 32'd1 : 32'd0, 32'd1);
        rst_n = 1'b0; quiet();
        dump_q.delete(); dq1.delete(); dq0.delete(); busy_q.delete(); ldr_q.delete();
        m_dump = 1'b0; m_restore = 1'b0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        base_done = done_cnt;
        reset_checks();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        read_all();
        step();
        chk("abort_no_done", done_cnt - base_done, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
